obs_motion: RTL and testbench
=============================

Name: obs_motion

Overview:
- Upstream feeder of the obstacle sprite renderer: owns the obstacle's horizontal position and drives the renderer's obstacle x-position input.
- Once per video frame it scrolls the obstacle left by the current speed, retires it at the left edge, then waits a pseudo-random number of frames before respawning at the right edge.
- Also emits a one-cycle "obstacle passed" pulse for the score logic.

Parameters:
- CONV, 0, coordinate right-shift; o_xpos is [9:CONV], same convention as the renderer's position inputs.
- SPAWN_X, 656, respawn x position in o_xpos LSB units (640 visible + 16 sprite width at CONV=0).
- MIN_GAP, 20, minimum frames between retire and respawn.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_frame_tick  input  1  one-cycle pulse per frame, at vblank start
- i_run  input  1  1 = game running; 0 = freeze motion (game over / pause)
- i_restart  input  1  one-cycle pulse; clears obstacle and restarts the spawn gap
- i_speed  input  4  pixels (o_xpos LSBs) moved per frame
- o_xpos  output  [9:CONV]  obstacle right-edge position to the renderer; 0 = off-screen
- o_active  output  1  obstacle on screen (state MOVE)
- o_passed  output  1  one-cycle pulse when an obstacle retires at the left edge

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, o_xpos=0, o_active=0, o_passed=0, gap counter=0, LFSR=LFSR_SEED. All outputs are registered.
- Position 0 renders nothing: the sprite spans x in [o_xpos-16, o_xpos-1], which wraps off-screen.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Advances every clock while rst_n is high, regardless of state, so gap timing depends on player input timing.
- FSM states: IDLE, WAIT, MOVE.
- IDLE:
  - o_xpos=0.
  - If i_run=1 on an i_frame_tick: load gap = MIN_GAP + lfsr[3:0], go to WAIT.
- WAIT:
  - o_xpos=0.
  - On each i_frame_tick with i_run=1: if gap==0, set o_xpos=SPAWN_X and go to MOVE; otherwise decrement gap.
  - Resulting spawn delay: MIN_GAP+r+1 ticks after entering WAIT, where r = lfsr[3:0] at load time.
- MOVE, on each i_frame_tick with i_run=1 (effective speed s, see Optional Feature):
  - If o_xpos > s: o_xpos <= o_xpos - s.
  - Else: o_xpos <= 0, o_passed pulses for one cycle, gap is loaded from the LFSR as in IDLE, go to WAIT.
  - Subtraction never underflows.
- s = 0: position holds; no retire.
- i_run=0: every state holds, o_xpos is frozen and stays visible (the game-over frame shows the obstacle). Frame ticks are ignored.
- i_restart: synchronous, highest priority over i_frame_tick and i_run in the same cycle.
  - Forces state IDLE, o_xpos=0, o_active=0, o_passed=0, gap=0.
  - The LFSR is not reset.
- Update latency: o_xpos changes on the clock edge where i_frame_tick is sampled high, i.e. it is visible one cycle after the tick. The renderer adds its own 1-cycle pipeline.
- o_active is 1 exactly when state is MOVE.
- All arithmetic uses the o_xpos width (10-CONV bits). i_speed is zero-extended.

Optional Feature:
- Macro: OBS_SPEEDUP_EN.
- Defined:
  - A 3-bit bonus register (reset 0, cleared by i_restart) increments after every 8 o_passed pulses, using a 3-bit passed counter; bonus saturates at 7.
  - Effective speed s = i_speed + bonus, computed 5 bits wide with no truncation.
- Undefined:
  - s = i_speed. No bonus or passed-counter registers exist.

Test Plan:
- Reset then i_run=1, LFSR_SEED=8'hA5, MIN_GAP=20: count frame ticks → o_xpos goes 0→656 exactly MIN_GAP+r+1 ticks after IDLE exit, where r = the bench-model LFSR[3:0] at gap load; o_active rises with it.
- MOVE from 656 with i_speed=5: o_xpos sequence 651, 646, ..., 6, 1, then 0 (1 ≤ 5 retires). o_passed is high for exactly one cycle on that edge; state is WAIT.
- i_run dropped mid-MOVE at o_xpos=300 across 10 frame ticks → o_xpos stays 300, o_active stays 1; restoring i_run resumes 300→295 on the next tick.
- i_restart asserted in the same cycle as i_frame_tick in MOVE → next cycle o_xpos=0, o_active=0, state IDLE; no o_passed pulse.
- Asynchronous rst_n low mid-MOVE, between clock edges → o_xpos=0 and o_active=0 immediately, without waiting for a clock edge.
- With OBS_SPEEDUP_EN, i_speed=15: after 8 retirements the per-frame step is 16; after 56+ retirements it is 22 and stays 22. Without the macro, the step is always 15.

Source files
------------

// File: rtl/obs_motion.sv
`default_nettype none
// ============================================================================
// obs_motion : scrolls the obstacle left once per frame, retires it at the
//              left edge and respawns it after an LFSR-randomised frame gap.
//              Optional build macro OBS_SPEEDUP_EN: +1 bonus speed per 8 passes.
// Rev 1.0
// ============================================================================
module obs_motion #(
  parameter int unsigned CONV      = 0,
  parameter int unsigned SPAWN_X   = 656,
  parameter int unsigned MIN_GAP   = 20,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_frame_tick,
  input  logic          i_run,
  input  logic          i_restart,
  input  logic [3:0]    i_speed,
  output logic [9:CONV] o_xpos,
  output logic          o_active,
  output logic          o_passed
);

  localparam int W  = 10 - CONV;
  localparam int GW = $clog2(MIN_GAP + 16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MOVE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    xpos_q;
  logic            active_q;
  logic            passed_q;
  logic [GW-1:0]   gap_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_d;
  logic [GW-1:0]   gap_load;
  logic [W-1:0]    step;

`ifdef OBS_SPEEDUP_EN
  logic [2:0]      bonus_q;
  logic [2:0]      pcnt_q;
  logic [4:0]      spd_eff;
  assign spd_eff = {1'b0, i_speed} + {2'b00, bonus_q};
`else
  logic [3:0]      spd_eff;
  assign spd_eff = i_speed;
`endif

  // Taps for x^8+x^6+x^5+x^4+1
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign gap_load = GW'(MIN_GAP) + GW'(lfsr_q[3:0]);
  assign step     = W'(spd_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xpos_q   <= '0;
      active_q <= 1'b0;
      passed_q <= 1'b0;
      gap_q    <= '0;
      lfsr_q   <= LFSR_SEED;
`ifdef OBS_SPEEDUP_EN
      bonus_q  <= '0;
      pcnt_q   <= '0;
`endif
    end else begin
      lfsr_q   <= lfsr_d;
      passed_q <= 1'b0;
      if (i_restart) begin
        state_q  <= S_IDLE;
        xpos_q   <= '0;
        active_q <= 1'b0;
        gap_q    <= '0;
`ifdef OBS_SPEEDUP_EN
        bonus_q  <= '0;
        pcnt_q   <= '0;
`endif
      end else if (i_frame_tick && i_run) begin
        case (state_q)
          S_IDLE: begin
            gap_q   <= gap_load;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (gap_q == '0) begin
              xpos_q   <= W'(SPAWN_X);
              active_q <= 1'b1;
              state_q  <= S_MOVE;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          S_MOVE: begin
            // Retire when the step would reach or cross zero; no underflow.
            if (xpos_q > step) begin
              xpos_q <= xpos_q - step;
            end else begin
              xpos_q   <= '0;
              active_q <= 1'b0;
              passed_q <= 1'b1;
              gap_q    <= gap_load;
              state_q  <= S_WAIT;
`ifdef OBS_SPEEDUP_EN
              pcnt_q   <= pcnt_q + 1'b1;
              if (pcnt_q == 3'd7 && bonus_q != 3'd7) begin
                bonus_q <= bonus_q + 1'b1;
              end
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_xpos   = xpos_q;
  assign o_active = active_q;
  assign o_passed = passed_q;

endmodule
`default_nettype wire

// File: tb/tb_obs_motion.sv
`default_nettype none
// ============================================================================
// tb_obs_motion : vector table plus model-driven scoreboard for obs_motion.
// Rev 1.0
// ============================================================================
module tb_obs_motion;

  localparam int MIN_GAP = 20;
  localparam int SPAWN   = 656;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_frame_tick, i_run, i_restart;
  logic [3:0] i_speed;
  logic [9:0] o_xpos;
  logic       o_active, o_passed;

  obs_motion dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (i_frame_tick),
    .i_run        (i_run),
    .i_restart    (i_restart),
    .i_speed      (i_speed),
    .o_xpos       (o_xpos),
    .o_active     (o_active),
    .o_passed     (o_passed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic       a;
    logic       p;
    string      nm;
  } exp_t;

  typedef struct {
    logic       tick;
    logic       run;
    logic       rs;
    logic [3:0] spd;
    logic [9:0] x;
    logic       a;
    logic       p;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [7:0] lfsr_m;
  int         m_st, m_x, m_gap, m_bonus, m_pcnt, m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'b1011_1000)};
  end

  task automatic chk(input string nm, input logic [9:0] ax, input logic aa, input logic ap,
                     input logic [9:0] ex, input logic ea, input logic ep);
    n_tests++;
    if (ax !== ex || aa !== ea || ap !== ep) begin
      n_fail++;
      $display("FAIL %s: got x=%0d active=%0b passed=%0b, want x=%0d active=%0b passed=%0b",
               nm, ax, aa, ap, ex, ea, ep);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.nm, o_xpos, o_active, o_passed, e.x, e.a, e.p);
    end
  end

  task automatic model_reset();
    m_st = 0; m_x = 0; m_gap = 0; m_bonus = 0; m_pcnt = 0;
  endtask

  // Drive one cycle; the model advances and its result (or an override) is queued.
  task automatic drive(input logic tick, input logic run, input logic rs, input logic [3:0] spd,
                       input bit ovr, input logic [9:0] ex, input logic ea, input logic ep,
                       input string nm);
    exp_t e;
    int   s;
    bit   p;
    @(negedge clk);
    i_frame_tick = tick; i_run = run; i_restart = rs; i_speed = spd;
    p = 1'b0;
    if (rs) begin
      model_reset();
    end else if (tick && run) begin
      if (m_st == 0) begin
        m_r = int'(lfsr_m[3:0]); m_gap = MIN_GAP + m_r; m_st = 1;
      end else if (m_st == 1) begin
        if (m_gap == 0) begin m_x = SPAWN; m_st = 2; end
        else m_gap--;
      end else begin
        s = int'(spd) + m_bonus;
        if (m_x > s) m_x -= s;
        else begin
          m_x = 0; p = 1'b1; m_st = 1;
          m_r = int'(lfsr_m[3:0]); m_gap = MIN_GAP + m_r;
`ifdef OBS_SPEEDUP_EN
          m_pcnt++;
          if (m_pcnt == 8) begin m_pcnt = 0; if (m_bonus < 7) m_bonus++; end
`endif
        end
      end
    end
    if (ovr) begin e.x = ex; e.a = ea; e.p = ep; end
    else begin e.x = 10'(m_x); e.a = (m_st == 2); e.p = p; end
    e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick(input logic [3:0] spd, input string nm);
    drive(1'b1, 1'b1, 1'b0, spd, 1'b0, 10'd0, 1'b0, 1'b0, nm);
  endtask

  // Counts ticks from WAIT entry until the DUT shows the spawn position.
  task automatic spawn(input bit from_idle);
    bit seen;
    if (from_idle) tick(4'd5, "idle_exit");
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      tick(4'd5, "wait_tick");
      @(posedge clk); #2;
      if (o_xpos == 10'(SPAWN)) begin
        seen = 1'b1;
        n_tests++;
        if (k != MIN_GAP + m_r + 1) begin
          n_fail++;
          $display("FAIL spawn_delay: got %0d ticks, want %0d", k, MIN_GAP + m_r + 1);
        end
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL spawn_timeout: got no spawn in 40 ticks, want spawn at %0d", MIN_GAP + m_r + 1);
    end
  endtask

  task automatic run_out(input logic [3:0] spd);
    for (int i = 0; i < 200 && m_st == 2; i++) tick(spd, "move");
  endtask

  vec_t tbl[6];

  initial begin
    int exp_step;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd15, 10'd641, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 4'd0,  10'd641, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd15, 10'd641, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4'd15, 10'd626, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd15, 10'd626, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 4'd10, 10'd616, 1'b1, 1'b0};

    rst_n = 1'b0; i_frame_tick = 1'b0; i_run = 1'b0; i_restart = 1'b0; i_speed = 4'd0;
    model_reset(); m_r = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", o_xpos, o_active, o_passed, 10'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    drive(1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 10'd0, 1'b0, 1'b0, "idle_notick");
    spawn(1'b1);
    run_out(4'd5);
    drive(1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 10'd0, 1'b0, 1'b0, "passed_one_cycle");
    spawn(1'b0);

    foreach (tbl[i])
      drive(tbl[i].tick, tbl[i].run, tbl[i].rs, tbl[i].spd,
            1'b1, tbl[i].x, tbl[i].a, tbl[i].p, $sformatf("vec%0d", i));

    for (int i = 0; i < 21; i++) tick(4'd15, "to_300");
    tick(4'd1, "at_300");
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 10'd300, 1'b1, 1'b0, "frozen");
    drive(1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 10'd295, 1'b1, 1'b0, "resume");
    drive(1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 10'd0, 1'b0, 1'b0, "restart_tick");
    drive(1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 10'd0, 1'b0, 1'b0, "restart_hold");

    spawn(1'b1);
    tick(4'd5, "pre_async");
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", o_xpos, o_active, o_passed, 10'd0, 1'b0, 1'b0);
    model_reset();
    i_frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    spawn(1'b1);
    for (int n = 0; n < 58; n++) begin
      run_out(4'd15);
      spawn(1'b0);
    end
`ifdef OBS_SPEEDUP_EN
    exp_step = 22;
`else
    exp_step = 15;
`endif
    tick(4'd15, "final_step");
    @(posedge clk); #2;
    n_tests++;
    if (SPAWN - int'(o_xpos) != exp_step) begin
      n_fail++;
      $display("FAIL final_step: got step %0d, want %0d", SPAWN - int'(o_xpos), exp_step);
    end

    drive(1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 10'd0, 1'b0, 1'b0, "tail");
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
